// File: rtl/stack_tracker.sv
// stack_tracker: receives committed rows from the active row shifter,
// trims overhang against the row below, stacks them eight high, and reports
// level, score, win and loss. The stack is readable combinationally for the
// LED display driver.
module stack_tracker #(
   parameter int LEVELS = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       startGame,
   input  logic       rowValid,
   input  logic [7:0] rowData,
   input  logic       rowOk,
   output logic [7:0] prev,
   output logic [7:0] rowSel,
   output logic [2:0] level,
   output logic [3:0] score,
   output logic       busy,
   output logic       gameOver,
   output logic       win,
   input  logic [2:0] rdAddr,
   output logic [7:0] rdData
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PLAY  = 3'd1,
      CHECK = 3'd2,
      WIN   = 3'd3,
      LOSE  = 3'd4
   } state_t;

   // Index of the top level; reaching it with a good row ends the game.
   localparam logic [2:0] LAST = 3'(LEVELS - 1);

   state_t     state_q, state_d;
   logic [2:0] level_q, level_d;
   logic [3:0] score_q, score_d;
   logic [7:0] prev_q, prev_d;
   logic [7:0] cap_data_q, cap_data_d;
   logic       cap_ok_q, cap_ok_d;
   logic [7:0] rows_q [LEVELS];
   logic [7:0] rows_d [LEVELS];

   logic [7:0] support;
   logic [7:0] ovl;

   // Level 0 sits on the floor, so everything is supported there; above that,
   // only the bits that rest on the row below survive.
   assign support = (level_q == 3'd0) ? 8'hFF : rows_q[level_q - 3'd1];
   assign ovl     = cap_data_q & support;

   // Next-state and datapath updates; startGame overrides any pending row.
   always_comb begin
      state_d    = state_q;
      level_d    = level_q;
      score_d    = score_q;
      prev_d     = prev_q;
      cap_data_d = cap_data_q;
      cap_ok_d   = cap_ok_q;
      rows_d     = rows_q;

      if (startGame) begin
         rows_d  = '{default: '0};
         level_d = 3'd0;
         score_d = 4'd0;
         prev_d  = 8'h00;
         state_d = PLAY;
      end else begin
         case (state_q)
            PLAY: begin
               if (rowValid) begin
                  cap_data_d = rowData;
                  cap_ok_d   = rowOk;
                  state_d    = CHECK;
               end
            end
            CHECK: begin
               if (!cap_ok_q || (ovl == 8'h00)) begin
                  // A miss leaves the stack exactly as it was.
                  state_d = LOSE;
               end else begin
                  rows_d[level_q] = ovl;
                  score_d         = score_q + 4'd1;
                  if (level_q == LAST) begin
                     // Top reached: level stays put rather than wrapping.
                     state_d = WIN;
                  end else begin
                     level_d = level_q + 3'd1;
                     // The row just written supports the next shifter.
                     prev_d  = ovl;
                     state_d = PLAY;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Control and capture registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         level_q    <= 3'd0;
         score_q    <= 4'd0;
         prev_q     <= 8'h00;
         cap_data_q <= 8'h00;
         cap_ok_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         level_q    <= level_d;
         score_q    <= score_d;
         prev_q     <= prev_d;
         cap_data_q <= cap_data_d;
         cap_ok_q   <= cap_ok_d;
      end
   end

   // One register per stack level; kept in flops because the display reads
   // the stack combinationally.
   generate
      for (genvar gi = 0; gi < LEVELS; gi++) begin : g_row
         // Level gi storage.
         always_ff @(posedge clk) begin
            if (rst) begin
               rows_q[gi] <= 8'h00;
            end else begin
               rows_q[gi] <= rows_d[gi];
            end
         end
      end
   endgenerate

   assign level    = level_q;
   assign score    = score_q;
   assign prev     = prev_q;
   assign busy     = (state_q == CHECK);
   assign gameOver = (state_q == LOSE);
   assign win      = (state_q == WIN);
   // Only the shifter at the active level runs, and none while a row is judged.
   assign rowSel   = (state_q == PLAY) ? (8'h01 << level_q) : 8'h00;
   assign rdData   = rows_q[rdAddr];

endmodule

// File: tb/tb_stack_tracker.sv
// Testbench for stack_tracker: directed game scenarios followed by randomized
// games, all checked against a behavioural model of the game rules.
`timescale 1ns/1ps
module tb_stack_tracker;

   logic       clk;
   logic       rst;
   logic       startGame;
   logic       rowValid;
   logic [7:0] rowData;
   logic       rowOk;
   logic [7:0] prev;
   logic [7:0] rowSel;
   logic [2:0] level;
   logic [3:0] score;
   logic       busy;
   logic       gameOver;
   logic       win;
   logic [2:0] rdAddr;
   logic [7:0] rdData;

   int total = 0;
   int bad   = 0;

   // Model of the game: phase of play, the stack, level and score.
   localparam int M_IDLE  = 0;
   localparam int M_PLAY  = 1;
   localparam int M_JUDGE = 2;
   localparam int M_WON   = 3;
   localparam int M_LOST  = 4;

   int         m_state;
   int         m_level;
   int         m_score;
   logic [7:0] m_rows [8];
   logic [7:0] m_cap;
   bit         m_capok;

   stack_tracker #(.LEVELS(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .startGame(startGame),
      .rowValid (rowValid),
      .rowData  (rowData),
      .rowOk    (rowOk),
      .prev     (prev),
      .rowSel   (rowSel),
      .level    (level),
      .score    (score),
      .busy     (busy),
      .gameOver (gameOver),
      .win      (win),
      .rdAddr   (rdAddr),
      .rdData   (rdData)
   );

   initial clk = 1'b0;
   always #50 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 8; i++) m_rows[i] = 8'h00;
      m_level = 0;
      m_score = 0;
   endtask

   // Apply the game rules for one clock edge with the given inputs.
   task automatic model_edge(input bit r, input bit s, input bit v,
                             input logic [7:0] d, input bit ok);
      logic [7:0] kept;
      if (r) begin
         model_clear();
         m_state = M_IDLE;
      end else if (s) begin
         model_clear();
         m_state = M_PLAY;
      end else if (m_state == M_PLAY) begin
         if (v) begin
            m_cap   = d;
            m_capok = ok;
            m_state = M_JUDGE;
         end
      end else if (m_state == M_JUDGE) begin
         kept = (m_level == 0) ? m_cap : (m_cap & m_rows[m_level - 1]);
         if (!m_capok || kept == 8'h00) begin
            m_state = M_LOST;
         end else begin
            m_rows[m_level] = kept;
            m_score++;
            if (m_level == 7) m_state = M_WON;
            else begin
               m_level++;
               m_state = M_PLAY;
            end
         end
      end
   endtask

   // Drive one clock cycle of inputs; pulses are cleared just after the edge.
   task automatic cycle(input bit r, input bit s, input bit v,
                        input logic [7:0] d, input bit ok);
      @(negedge clk);
      rst = r; startGame = s; rowValid = v; rowData = d; rowOk = ok;
      @(posedge clk);
      model_edge(r, s, v, d, ok);
      #1;
      rst = 1'b0; startGame = 1'b0; rowValid = 1'b0;
   endtask

   // Compare every output and the whole stack with the model.
   task automatic check_all(input string tag);
      logic [7:0] exp_sel;
      logic [7:0] exp_prev;
      exp_sel  = (m_state == M_PLAY) ? (8'h01 << m_level) : 8'h00;
      exp_prev = (m_level == 0) ? 8'h00 : m_rows[m_level - 1];
      chk({tag, ".level"},    {5'b0, level},    8'(m_level));
      chk({tag, ".score"},    {4'b0, score},    8'(m_score));
      chk({tag, ".busy"},     {7'b0, busy},     {7'b0, (m_state == M_JUDGE)});
      chk({tag, ".gameOver"}, {7'b0, gameOver}, {7'b0, (m_state == M_LOST)});
      chk({tag, ".win"},      {7'b0, win},      {7'b0, (m_state == M_WON)});
      chk({tag, ".rowSel"},   rowSel,           exp_sel);
      chk({tag, ".prev"},     prev,             exp_prev);
      for (int a = 0; a < 8; a++) begin
         rdAddr = 3'(a);
         #1;
         chk($sformatf("%s.rd%0d", tag, a), rdData, m_rows[a]);
      end
   endtask

   // Present a row; if it is accepted, also check the one-cycle judge step.
   task automatic commit(input string tag, input logic [7:0] d, input bit ok);
      cycle(1'b0, 1'b0, 1'b1, d, ok);
      check_all({tag, ".cap"});
      if (m_state == M_JUDGE) begin
         cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
         check_all({tag, ".upd"});
      end
      $display("commit %s data=%h ok=%0d level=%0d score=%0d win=%0d over=%0d",
               tag, d, ok, level, score, win, gameOver);
   endtask

   task automatic start(input string tag);
      cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      check_all(tag);
      $display("start %s", tag);
   endtask

   function automatic logic [7:0] rand_block();
      int w;
      int p;
      logic [8:0] m;
      if ($urandom_range(0, 4) == 0) return 8'($urandom);
      w = $urandom_range(1, 8);
      p = $urandom_range(0, 8 - w);
      m = (9'h001 << w) - 9'h001;
      return 8'(m << p);
   endfunction

   initial begin
      rst = 1'b1; startGame = 1'b0; rowValid = 1'b0; rowData = 8'h00;
      rowOk = 1'b0; rdAddr = 3'd0;
      m_state = M_IDLE; m_cap = 8'h00; m_capok = 1'b0;
      model_clear();

      // Reset state.
      cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      check_all("reset");
      commit("idle_ignored", 8'hFF, 1'b1);

      // Two aligned rows with trimming, then an unsupported row.
      start("start1");
      commit("r0_3c", 8'h3C, 1'b1);
      commit("r1_1e", 8'h1E, 1'b1);
      commit("miss_c0", 8'hC0, 1'b1);
      commit("lose_ignored", 8'h3C, 1'b1);

      // Shifter says misaligned.
      start("start2");
      commit("notok_18", 8'h18, 1'b0);

      // Full stack of 0xFF wins; further rows ignored.
      start("start3");
      for (int i = 0; i < 8; i++) commit($sformatf("ff%0d", i), 8'hFF, 1'b1);
      commit("win_ignored", 8'hFF, 1'b1);
      start("restart_after_win");

      // startGame and rowValid together at level 3.
      commit("c0", 8'hF0, 1'b1);
      commit("c1", 8'h70, 1'b1);
      commit("c2", 8'h30, 1'b1);
      cycle(1'b0, 1'b1, 1'b1, 8'h30, 1'b1);
      check_all("collide");

      // Reset while judging a row.
      cycle(1'b0, 1'b0, 1'b1, 8'hFF, 1'b1);
      check_all("pre_rst");
      cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      check_all("rst_in_check");
      start("start4");

      // Randomized games.
      for (int g = 0; g < 20; g++) begin
         start($sformatf("rg%0d", g));
         for (int k = 0; k < 12; k++) begin
            int act;
            act = $urandom_range(0, 19);
            if (act == 0) begin
               cycle(1'b0, 1'b1, 1'b1, rand_block(), 1'b1);
               check_all($sformatf("rg%0d_collide%0d", g, k));
            end else if (act == 1) begin
               cycle(1'b0, 1'b0, 1'b1, rand_block(), 1'b1);
               cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
               check_all($sformatf("rg%0d_rst%0d", g, k));
               start($sformatf("rg%0d_rs%0d", g, k));
            end else begin
               commit($sformatf("rg%0d_%0d", g, k), rand_block(),
                      ($urandom_range(0, 9) != 0));
            end
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/stack_tracker.md
# stack_tracker

Receiving end of the row-shifter interface in the stacker game. It accepts each committed row (`rowData`/`rowOk`) from the active shifter and stores it in an 8-level stack, trimming overhang against the row below. It feeds the supporting row back to the shifters on `prev` and advances the active level. It detects win and loss, keeps a score, and exposes the stack for the LED display driver.

## Interface
Parameters:
- `LEVELS`, 8: stack height; the level index is 3 bits.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `startGame`  in  1  one-cycle pulse; clears the stack and begins play.
- `rowValid`  in  1  one-cycle pulse; the shifter has stopped and `rowData`/`rowOk` are valid.
- `rowData`  in  8  stopped block position from the shifter.
- `rowOk`  in  1  shifter's own alignment verdict; 1 means aligned.
- `prev`  out  8  supporting row for the active shifter: `row[level-1]`, or 0 at level 0.
- `rowSel`  out  8  one-hot enable for the active shifter; `1<<level` in PLAY, 0 otherwise.
- `level`  out  3  current level index.
- `score`  out  4  rows successfully stacked, 0..8.
- `busy`  out  1  high in CHECK.
- `gameOver`  out  1  high in LOSE.
- `win`  out  1  high in WIN.
- `rdAddr`  in  3  display read address.
- `rdData`  out  8  `row[rdAddr]`, combinational.

## Operation
States:
- IDLE: waits for `startGame`.
- PLAY: waits for `rowValid`.
- CHECK: evaluates the captured row.
- WIN: terminal until `startGame`.
- LOSE: terminal until `startGame`.

Priority: `rst` > `startGame` > `rowValid`.

Reset:
- All rows = 0, `level` = 0, `score` = 0, state IDLE.
- All outputs are 0, except `rdData`, which reads 0 because the rows are cleared.

`startGame`:
- Accepted in any state, including CHECK.
- Clears all rows, `level` and `score`, then goes to PLAY.
- If `startGame` and `rowValid` occur in the same cycle, `rowValid` is dropped.

PLAY:
- On `rowValid`, latch `rowData` into `capData` and `rowOk` into `capOk`, then go to CHECK.

CHECK (exactly one cycle; `rowValid` is ignored):
- Compute `ovl = (level==0) ? capData : capData & row[level-1]`.
- LOSE if `capOk==0` or `ovl==0`. The stack, `level` and `score` are unchanged.
- Otherwise:
  - `row[level] <= ovl`, `score <= score+1`.
  - If `level==LEVELS-1`, go to WIN; `level` stays 7 (no wrap).
  - Else `level <= level+1` and go to PLAY.

Overhang trimming:
- Bits of `capData` not supported by the row below are discarded.
- Row width is non-increasing up the stack.

`rowValid` is ignored in IDLE, CHECK, WIN and LOSE.

`prev` is registered and updates together with `level`.

## Timing
Commit latency:
- `rowValid` sampled at edge N; CHECK and `busy` are high after edge N.
- Edge N+1 writes the row and updates `level`, `prev`, `rowSel`, `score`, `win`/`gameOver`.
- The next `rowValid` is accepted at edge N+2 at the earliest.

`rowSel` goes to 0 during CHECK, so the next shifter starts cleanly after the update.

`rdData` follows `rdAddr` in the same cycle and reflects a row write on the cycle after edge N+1.

`startGame` takes effect at the next edge: PLAY with `rowSel`=0x01 and `prev`=0x00.

`rst` mid-game (including during CHECK) returns to IDLE at the next edge and discards the captured row.

## Test plan
- Reset, then `startGame` -> state PLAY, `level`=0, `rowSel`=0x01, `prev`=0x00, `score`=0, all `rdData`=0x00.
- Commit `rowData`=0x3C (`rowOk`=1), then 0x1E (`rowOk`=1) -> `row[0]`=0x3C, `row[1]`=0x1C, `prev`=0x1C, `level`=2, `score`=2; each `busy` pulse is exactly 1 cycle.
- From the previous state, commit `rowData`=0xC0 -> `ovl`=0, `gameOver`=1, `rowSel`=0; `level`, `score` and the stack are unchanged. A subsequent `rowValid` is ignored.
- From fresh play, commit `rowData`=0x18 with `rowOk`=0 -> LOSE, `row[0]` stays 0x00.
- Eight consecutive commits of 0xFF -> `win`=1, `level`=7, `score`=8, `rdData`=0xFF for all addresses. A 9th `rowValid` is ignored. `startGame` then clears everything and returns to PLAY.
- Apply `rowValid` and `startGame` in the same cycle at `level`=3 -> stack cleared, `level`=0, no CHECK entered. Assert `rst` during CHECK -> IDLE, `row[level]` not written.
